alu_share_arb: RTL and testbench
================================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter NREQ, default 2, number of requesters; supported range 2..4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  NREQ  per-requester operation request.
REQ-005 req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-006 req_aluop  input  2*NREQ  packed aluop; slice i belongs to requester i.
REQ-007 req_func  input  10*NREQ  packed funcCode {funct7,funct3}; slice i belongs to requester i.
REQ-008 req_a, req_b  input  8*NREQ  packed operands; slice i belongs to requester i.
REQ-009 alu_aluop/alu_func/alu_a/alu_b  output  2/10/8/8  drive the shared ALU top.
REQ-010 alu_result/alu_zero/alu_carry/alu_ovf  input  8/1/1/1  combinational results from the shared ALU top.
REQ-011 rsp_valid  output  NREQ  per-requester response valid.
REQ-012 rsp_ready  input  NREQ  per-requester response accept.
REQ-013 rsp_result/rsp_zero/rsp_carry/rsp_ovf  output  8/1/1/1  registered response, common to all requesters.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and RESP, with at most one operation outstanding.
REQ-016 In IDLE, the block SHALL assert req_ready only for the grant index g, chosen among asserted req_valid bits.
REQ-017 On an IDLE edge with req_valid[g]: latch g and the aluop/func/a/b of requester g; go to EXEC.
REQ-018 alu_* outputs SHALL always drive the latched operand registers; they change only on accept.
REQ-019 On the EXEC edge, the block SHALL capture alu_result/zero/carry/ovf into the rsp_* registers and go to RESP.
REQ-020 In RESP, rsp_valid[g] SHALL be high and all other rsp_valid bits low.
REQ-021 On a RESP edge with rsp_ready[g]: return to IDLE; no new accept occurs on that same edge.
REQ-022 Timing SHALL be: accept edge N, then rsp_valid high in the cycle after edge N+1, so minimum issue-to-issue spacing is 3 cycles.
REQ-023 rsp_* values SHALL stay stable while rsp_valid is high and not yet accepted, however long rsp_ready stays low.
REQ-024 rsp_ready on non-granted bits, and req_valid changes outside IDLE, SHALL be ignored.
REQ-025 With no req_valid asserted in IDLE, the block SHALL hold all state and keep req_ready at zero.

Reset
REQ-026 On reset: state IDLE, req_ready 0, rsp_valid 0, rsp_* 0, latched operands and alu_* 0, round-robin pointer pointing at requester 0.
REQ-027 Reset asserted in EXEC or RESP SHALL abort the operation and drop the pending response without asserting rsp_valid.
REQ-028 In the first cycle after reset is released, the block SHALL accept requests normally.

Configuration
REQ-029 When ALU_ARB_RR_EN is defined: round-robin arbitration, with the search starting at the index after the last granted requester and wrapping from NREQ-1 to 0.
REQ-030 When ALU_ARB_RR_EN is undefined: fixed priority, lowest index wins, and the pointer logic is absent.

Structure
REQ-031 The shared package alu_arb_pkg SHALL hold the state encodings (IDLE=2'd0, EXEC=2'd1, RESP=2'd2), the ALU field widths (2, 10, 8), and the aluop constants (LDST=2'b00, BR=2'b01, RTYPE=2'b10).
REQ-032 Grant selection SHALL live in a sub-module arb_pick (inputs: req vector, pointer; output: one-hot grant plus index); the FSM and registers stay in alu_share_arb.

Verification
REQ-033 Single ADD: requester 0, aluop=2'b10, func=10'b0000000_000, a=8'h7F, b=8'h01 -> rsp_valid[0] two cycles after accept; result 8'h80, ovf 1, zero 0.
REQ-034 SUB to zero: requester 1, aluop=2'b10, func=10'b0100000_000, a=b=8'h05 -> result 8'h00, zero 1, rsp_valid[1] only.
REQ-035 Contention with ALU_ARB_RR_EN: both requesters valid continuously for 4 ops -> grants alternate 0,1,0,1; without the macro -> grants 0,0,0,0.
REQ-036 Backpressure: hold rsp_ready low for 5 cycles in RESP -> rsp_* stable, busy 1, req_ready 0; accept on cycle 6, then the next grant follows.
REQ-037 Reset during EXEC -> next cycle state IDLE, rsp_valid 0, all rsp_* 0, and the next request is accepted with correct results.
REQ-038 Invalid aluop 2'b11 from requester 0 -> handshake completes normally, and rsp_result equals whatever the ALU returned for that aluop (passthrough, with no response generated by the block itself).

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the shared-ALU arbiter: FSM states, ALU field
// widths, aluop codes and the latched operation / response records.
package alu_arb_pkg;

    localparam int AOP_W  = 2;
    localparam int FUNC_W = 10;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [AOP_W-1:0] LDST  = 2'b00;
    localparam logic [AOP_W-1:0] BR    = 2'b01;
    localparam logic [AOP_W-1:0] RTYPE = 2'b10;

    typedef struct packed {
        logic [AOP_W-1:0]  aluop;
        logic [FUNC_W-1:0] func;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } op_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              carry;
        logic              ovf;
    } rsp_t;

    // Index width for an n-entry requester vector (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Requester-side request/response bundle of the shared-ALU arbiter.
// master = requesters, slave = arbiter.
interface alu_share_arb_if #(parameter int NREQ = 2);
    import alu_arb_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*AOP_W-1:0]  req_aluop;
    logic [NREQ*FUNC_W-1:0] req_func;
    logic [NREQ*DATA_W-1:0] req_a;
    logic [NREQ*DATA_W-1:0] req_b;

    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]      rsp_result;
    logic                   rsp_zero;
    logic                   rsp_carry;
    logic                   rsp_ovf;

    modport master (
        output req_valid, req_aluop, req_func, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf
    );

    modport slave (
        input  req_valid, req_aluop, req_func, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf
    );

endinterface

// File: rtl/alu_share_arb_pick.sv
// Grant picker: first asserted request found when searching upward from ptr,
// wrapping at NREQ-1. With ptr tied to zero this is fixed lowest-index priority.
module arb_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic found;
    int   c;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int off = 0; off < NREQ; off++) begin
            c = int'(ptr) + off;
            if (c >= NREQ) c = c - NREQ;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between NREQ requesters, one operation at a time.
// Define ALU_ARB_RR_EN for round-robin grants; otherwise lowest index wins.
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              reset,
    alu_share_arb_if.slave    bus,
    output logic [AOP_W-1:0]  alu_aluop,
    output logic [FUNC_W-1:0] alu_func,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    output logic              busy
);

    localparam int IW = idx_w(NREQ);

    state_t          state, nstate;
    op_t             op_q, op_sel;
    rsp_t            rsp_q;
    logic [IW-1:0]   g_q;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] pick_gnt;
    logic            accept;
    logic            rsp_done;

    arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign accept   = (state == IDLE) && (|bus.req_valid);
    assign rsp_done = (state == RESP) && bus.rsp_ready[g_q];

`ifdef ALU_ARB_RR_EN
    // Search for the next grant starts just past the last winner.
    logic [IW-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (reset)       ptr_q <= '0;
        else if (accept) ptr_q <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    // Operand slice of the winning requester; grant is one-hot so an OR-style mux is safe.
    always_comb begin
        op_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                op_sel.aluop = bus.req_aluop[i*AOP_W +: AOP_W];
                op_sel.func  = bus.req_func[i*FUNC_W +: FUNC_W];
                op_sel.a     = bus.req_a[i*DATA_W +: DATA_W];
                op_sel.b     = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (accept)   nstate = EXEC;
            EXEC:                  nstate = RESP;
            RESP:    if (rsp_done) nstate = IDLE;
            default:               nstate = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        busy          = (state != IDLE);
        case (state)
            IDLE:    bus.req_ready = pick_gnt;
            RESP:    bus.rsp_valid[g_q] = 1'b1;
            default: ;
        endcase
    end

    // Operands move only on accept; the response is captured once, in EXEC,
    // so rsp_* stays frozen through any amount of backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= '0;
            g_q   <= '0;
            rsp_q <= '0;
        end else begin
            if (accept) begin
                op_q <= op_sel;
                g_q  <= pick_idx;
            end
            if (state == EXEC) begin
                rsp_q <= '{result: alu_result, zero: alu_zero, carry: alu_carry, ovf: alu_ovf};
            end
        end
    end

    assign alu_aluop      = op_q.aluop;
    assign alu_func       = op_q.func;
    assign alu_a          = op_q.a;
    assign alu_b          = op_q.b;
    assign bus.rsp_result = rsp_q.result;
    assign bus.rsp_zero   = rsp_q.zero;
    assign bus.rsp_carry  = rsp_q.carry;
    assign bus.rsp_ovf    = rsp_q.ovf;

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized self-checking bench for alu_share_arb; also stands in as the shared ALU.
module tb_alu_share_arb;
    import alu_arb_pkg::*;

    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_share_arb_if #(.NREQ(NREQ)) bus();

    logic [AOP_W-1:0]  alu_aluop;
    logic [FUNC_W-1:0] alu_func;
    logic [7:0]        alu_a, alu_b, alu_result;
    logic              alu_zero, alu_carry, alu_ovf, busy;
    logic              corrupt = 1'b0;

    logic [AOP_W-1:0]  t_aop  [NREQ];
    logic [FUNC_W-1:0] t_func [NREQ];
    logic [7:0]        t_a    [NREQ];
    logic [7:0]        t_b    [NREQ];

    int n_chk  = 0;
    int n_fail = 0;
    int rr_ptr = 0;
    logic [27:0] last_op = '0;

    wire [10:0] rsp_bus = {bus.rsp_ovf, bus.rsp_carry, bus.rsp_zero, bus.rsp_result};
    wire [27:0] alu_bus = {alu_aluop, alu_func, alu_a, alu_b};

    alu_share_arb #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .alu_aluop  (alu_aluop),
        .alu_func   (alu_func),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .alu_ovf    (alu_ovf),
        .busy       (busy)
    );

    // Reference ALU, returns {ovf, carry, zero, result}.
    function automatic logic [10:0] alu_ref(input logic [1:0] op, input logic [9:0] f,
                                            input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic c, v, sub;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        if (op == 2'b11) begin
            r = a ^ b ^ 8'h3C;
            return {2'b00, (r == 8'h00), r};
        end
        sub = (op == BR) || (op == RTYPE && f[2:0] == 3'b000 && f[9:3] == 7'b0100000);
        if      (op == RTYPE && f[2:0] == 3'b111) r = a & b;
        else if (op == RTYPE && f[2:0] == 3'b110) r = a | b;
        else if (op == RTYPE && f[2:0] == 3'b100) r = a ^ b;
        else if (sub) begin
            s = {1'b0, a} - {1'b0, b};
            r = s[7:0]; c = s[8];
            v = (a[7] != b[7]) && (r[7] != a[7]);
        end else begin
            s = {1'b0, a} + {1'b0, b};
            r = s[7:0]; c = s[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
        end
        return {v, c, (r == 8'h00), r};
    endfunction

    // During RESP the ALU output is scrambled: a correct arbiter never re-samples it.
    always_comb begin
        {alu_ovf, alu_carry, alu_zero, alu_result} =
            alu_ref(alu_aluop, alu_func, alu_a, alu_b) ^ (corrupt ? 11'h7FF : 11'h000);
    end

    always_comb begin
        bus.req_aluop = '0;
        bus.req_func  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_aluop[i*AOP_W +: AOP_W]   = t_aop[i];
            bus.req_func[i*FUNC_W +: FUNC_W]  = t_func[i];
            bus.req_a[i*8 +: 8]               = t_a[i];
            bus.req_b[i*8 +: 8]               = t_b[i];
        end
    end

    function automatic int model_pick(input logic [NREQ-1:0] v);
        int i;
        for (int k = 0; k < NREQ; k++) begin
            i = (rr_ptr + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [9:0] rand_func();
        case ($urandom_range(0, 5))
            0:       return 10'h000;
            1:       return 10'h100;
            2:       return 10'h007;
            3:       return 10'h006;
            4:       return 10'h004;
            default: return 10'($urandom);
        endcase
    endfunction

    task automatic scramble_ops();
        for (int i = 0; i < NREQ; i++) begin
            t_aop[i]  = 2'($urandom);
            t_func[i] = rand_func();
            t_a[i]    = 8'($urandom);
            t_b[i]    = 8'($urandom);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic note_grant(input int g);
`ifdef ALU_ARB_RR_EN
        rr_ptr = (g + 1) % NREQ;
`else
        rr_ptr = 0;
`endif
    endtask

    // One complete operation from IDLE back to IDLE.
    task automatic issue(input logic [NREQ-1:0] vmask, input int hold,
                         input bit chk_lit, input logic [10:0] lit);
        int g;
        logic [NREQ-1:0] one;
        logic [NREQ-1:0] gbit;
        logic [10:0] exp;
        logic [27:0] eop;
        one = 1;
        g = model_pick(vmask);
        gbit = one << g;
        eop = {t_aop[g], t_func[g], t_a[g], t_b[g]};
        exp = alu_ref(t_aop[g], t_func[g], t_a[g], t_b[g]);
        bus.req_valid = vmask;
        #1;
        n_chk++;
        if ({busy, bus.req_ready} !== {1'b0, gbit}) begin
            n_fail++;
            $display("FAIL idle_grant: busy/ready %b/%b want 0/%b", busy, bus.req_ready, gbit);
        end
        step();
        note_grant(g);
        last_op = eop;
        // Post-accept request traffic and operand changes must be ignored.
        bus.req_valid = NREQ'($urandom);
        scramble_ops();
        #1;
        n_chk++;
        if ({busy, bus.req_ready, bus.rsp_valid, alu_bus} !== {1'b1, {NREQ{1'b0}}, {NREQ{1'b0}}, eop}) begin
            n_fail++;
            $display("FAIL exec_state: busy %b ready %b rsp_valid %b alu %h want 1 0 0 %h",
                     busy, bus.req_ready, bus.rsp_valid, alu_bus, eop);
        end
        step();
        n_chk++;
        if ({bus.rsp_valid, rsp_bus} !== {gbit, exp}) begin
            n_fail++;
            $display("FAIL resp: rsp_valid %b rsp %h want %b %h", bus.rsp_valid, rsp_bus, gbit, exp);
        end
        if (chk_lit) begin
            n_chk++;
            if (rsp_bus !== lit) begin
                n_fail++;
                $display("FAIL resp_literal: rsp %h want %h", rsp_bus, lit);
            end
        end
        corrupt = 1'b1;
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = NREQ'($urandom) & ~gbit;
            step();
            n_chk++;
            if ({busy, bus.req_ready, bus.rsp_valid, rsp_bus} !== {1'b1, {NREQ{1'b0}}, gbit, exp}) begin
                n_fail++;
                $display("FAIL backpressure: busy %b ready %b rsp_valid %b rsp %h want 1 0 %b %h",
                         busy, bus.req_ready, bus.rsp_valid, rsp_bus, gbit, exp);
            end
        end
        // Requests held high across the return edge must not be accepted on it.
        bus.rsp_ready = gbit | NREQ'($urandom);
        bus.req_valid = '1;
        step();
        corrupt = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        #1;
        n_chk++;
        if ({busy, bus.rsp_valid, alu_bus} !== {1'b0, {NREQ{1'b0}}, eop}) begin
            n_fail++;
            $display("FAIL return_idle: busy %b rsp_valid %b alu %h want 0 0 %h",
                     busy, bus.rsp_valid, alu_bus, eop);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        scramble_ops();
        repeat (3) step();
        n_chk++;
        if ({busy, bus.req_ready, bus.rsp_valid, rsp_bus, alu_bus} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy %b ready %b rsp_valid %b rsp %h alu %h want all 0",
                     busy, bus.req_ready, bus.rsp_valid, rsp_bus, alu_bus);
        end
        reset = 1'b0;
        rr_ptr = 0;
    endtask

    task automatic test_add();
        scramble_ops();
        t_aop[0] = RTYPE; t_func[0] = 10'b0000000_000; t_a[0] = 8'h7F; t_b[0] = 8'h01;
        issue(2'b01, 0, 1'b1, {1'b1, 1'b0, 1'b0, 8'h80});
    endtask

    task automatic test_sub_zero();
        scramble_ops();
        t_aop[1] = RTYPE; t_func[1] = 10'b0100000_000; t_a[1] = 8'h05; t_b[1] = 8'h05;
        issue(2'b10, 1, 1'b1, {1'b0, 1'b0, 1'b1, 8'h00});
    endtask

    task automatic test_invalid_op();
        scramble_ops();
        t_aop[0] = 2'b11;
        issue(2'b01, 2, 1'b0, '0);
    endtask

    task automatic test_idle_hold();
        bus.req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            scramble_ops();
            step();
            n_chk++;
            if ({busy, bus.req_ready, bus.rsp_valid, alu_bus} !== {1'b0, {NREQ{1'b0}}, {NREQ{1'b0}}, last_op}) begin
                n_fail++;
                $display("FAIL idle_hold: busy %b ready %b rsp_valid %b alu %h want 0 0 0 %h",
                         busy, bus.req_ready, bus.rsp_valid, alu_bus, last_op);
            end
        end
    endtask

    task automatic test_backpressure();
        scramble_ops();
        issue(2'b11, 5, 1'b0, '0);
        scramble_ops();
        issue(2'b11, 0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        int obs[$];
        int icyc[$];
        int pend_g, nrsp, cyc, o;
        int exp_seq[4];
        logic [10:0] pend_exp;
        logic [NREQ-1:0] one;
        one = 1; nrsp = 0; cyc = 0; pend_g = 0; pend_exp = '0;
`ifdef ALU_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        reset = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        step();
        reset = 1'b0;
        rr_ptr = 0;
        scramble_ops();
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        #1;
        while (nrsp < 4 && cyc < 60) begin
            if (bus.req_ready != '0) begin
                pend_g = model_pick('1);
                n_chk++;
                if (bus.req_ready !== (one << pend_g)) begin
                    n_fail++;
                    $display("FAIL rr_grant: ready %b want %b", bus.req_ready, one << pend_g);
                end
                o = -1;
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) o = i;
                obs.push_back(o);
                icyc.push_back(cyc);
                pend_exp = alu_ref(t_aop[pend_g], t_func[pend_g], t_a[pend_g], t_b[pend_g]);
                note_grant(pend_g);
            end else if (bus.rsp_valid != '0) begin
                nrsp++;
                n_chk++;
                if ({bus.rsp_valid, rsp_bus} !== {one << pend_g, pend_exp}) begin
                    n_fail++;
                    $display("FAIL rr_resp: rsp_valid %b rsp %h want %b %h",
                             bus.rsp_valid, rsp_bus, one << pend_g, pend_exp);
                end
            end
            if (busy) scramble_ops();
            step();
            cyc++;
        end
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        n_chk++;
        if (nrsp < 4 || obs.size() < 4) begin
            n_fail++;
            $display("FAIL rr_timeout: responses %0d grants %0d want 4 4", nrsp, obs.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_chk++;
                if (obs[k] != exp_seq[k]) begin
                    n_fail++;
                    $display("FAIL rr_sequence[%0d]: grant %0d want %0d", k, obs[k], exp_seq[k]);
                end
            end
            for (int k = 1; k < 4; k++) begin
                n_chk++;
                if (icyc[k] - icyc[k-1] != 3) begin
                    n_fail++;
                    $display("FAIL issue_spacing[%0d]: %0d cycles want 3", k, icyc[k] - icyc[k-1]);
                end
            end
        end
        step();
    endtask

    // Reset in EXEC (abort=1) or in RESP (abort=2), then immediate reuse.
    task automatic test_reset_abort(input int abort_at);
        scramble_ops();
        bus.req_valid = 2'b01;
        step();
        note_grant(0);
        bus.req_valid = '0;
        if (abort_at == 2) step();
        reset = 1'b1;
        step();
        n_chk++;
        if ({busy, bus.req_ready, bus.rsp_valid, rsp_bus, alu_bus} !== '0) begin
            n_fail++;
            $display("FAIL reset_abort%0d: busy %b ready %b rsp_valid %b rsp %h alu %h want all 0",
                     abort_at, busy, bus.req_ready, bus.rsp_valid, rsp_bus, alu_bus);
        end
        reset = 1'b0;
        rr_ptr = 0;
        scramble_ops();
        issue(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 0, 1'b0, '0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            scramble_ops();
            issue(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 3), 1'b0, '0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        scramble_ops();
        #1;
        test_reset();
        test_add();
        test_sub_zero();
        test_idle_hold();
        test_invalid_op();
        test_backpressure();
        test_back_to_back();
        test_reset_abort(1);
        test_reset_abort(2);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
